// File: rtl/uart_pkg.sv
// Shared UART types and constant helpers, used by both the RX and TX paths.
// No logic: enum, baud arithmetic and parity helper only.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    function automatic int uart_bit_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int uart_half_cnt(input int bit_cnt);
        return bit_cnt / 2;
    endfunction

    // Narrower characters are zero-extended, which leaves the XOR unchanged.
    function automatic logic par_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// RX line synchroniser, falling-edge detect and 3-point majority vote.
// Latency: SYNC_STAGES clocks to line; sample_bit is valid at baud count HALF+1. No backpressure.
module uart_bit_sampler #(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [CNT_W-1:0] baud_cnt,
    input  logic [CNT_W-1:0] half,
    output logic             fall_edge,
    output logic             sample_bit,
    output logic             line
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_d;
    logic                   smp_a;
    logic                   smp_b;

    // Flops reset to 1 so that reset release never resembles a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            line_d <= 1'b1;
            smp_a  <= 1'b1;
            smp_b  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            line_d <= sync_q[SYNC_STAGES-1];
            if (baud_cnt == half - CNT_W'(1)) smp_a <= sync_q[SYNC_STAGES-1];
            if (baud_cnt == half)             smp_b <= sync_q[SYNC_STAGES-1];
        end
    end

    assign line       = sync_q[SYNC_STAGES-1];
    assign fall_edge  = line_d & ~line;
    assign sample_bit = (smp_a & smp_b) | (smp_a & line) | (smp_b & line);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits, break and framing detection.
// Latency: result one clock after the final stop-bit mid-point decision. No backpressure (single-cycle valid).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUDRATE    = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx_i,
    output logic                 rx_valid_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int BIT_CNT = uart_bit_cnt(CLK_FREQ, BAUDRATE);
    localparam int HALF    = uart_half_cnt(BIT_CNT);
    localparam int CNT_W   = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] DECIDE    = CNT_W'(HALF + 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    if (BIT_CNT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_EN < 0 || PARITY_EN > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2)
    begin : g_param_check
        $error("uart_rx_cfg: illegal parameter set");
    end

    rx_state_t              state, state_nx;
    logic [CNT_W-1:0]       baud_cnt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit, par_err_r, frame_err_r, stop0_r;
    logic                   fall_edge, sample_bit, line;
    logic                   decide, wrap, done, brk, stop0;

    uart_bit_sampler #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx_i),
        .baud_cnt  (baud_cnt),
        .half      (HALF_C),
        .fall_edge (fall_edge),
        .sample_bit(sample_bit),
        .line      (line)
    );

    assign decide = (baud_cnt == DECIDE);
    assign wrap   = (baud_cnt == CNT_LAST);
    assign stop0  = LAST_STOP ? stop0_r : sample_bit;
    assign brk    = (shreg == '0) && ((PARITY_EN == 0) || !par_bit) && !stop0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (fall_edge) state_nx = ST_START;
            ST_START:    if (decide && sample_bit) state_nx = ST_IDLE;
                         else if (wrap)            state_nx = ST_DATA;
            ST_DATA:     if (wrap && bit_idx == LAST_DATA)
                             state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:   if (wrap) state_nx = ST_STOP;
            // Leave at the final stop mid-point, giving half a bit of slack before the next start.
            ST_STOP:     if (decide && stop_idx == LAST_STOP)
                             state_nx = brk ? ST_BRK_WAIT : ST_IDLE;
            ST_BRK_WAIT: if (line && hi_cnt == HALF_C - CNT_W'(1)) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != ST_IDLE);
        done   = (state == ST_STOP) && decide && (stop_idx == LAST_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt    <= '0;
            hi_cnt      <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            stop0_r     <= 1'b0;
        end else begin
            if (state == ST_IDLE || state_nx != state || wrap) baud_cnt <= '0;
            else                                                baud_cnt <= baud_cnt + CNT_W'(1);

            if (state == ST_BRK_WAIT && line) hi_cnt <= hi_cnt + CNT_W'(1);
            else                              hi_cnt <= '0;

            if (state_nx != state)             bit_idx <= '0;
            else if (state == ST_DATA && wrap) bit_idx <= bit_idx + 4'd1;

            if (state_nx != state)             stop_idx <= 1'b0;
            else if (state == ST_STOP && wrap) stop_idx <= 1'b1;

            if (state == ST_IDLE) begin
                par_bit     <= 1'b0;
                par_err_r   <= 1'b0;
                frame_err_r <= 1'b0;
            end

            if (decide) begin
                case (state)
                    ST_DATA:   shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
                    ST_PARITY: begin
                        par_bit   <= sample_bit;
                        par_err_r <= sample_bit != par_calc(9'(shreg), PARITY_ODD != 0);
                    end
                    ST_STOP: begin
                        if (!sample_bit) frame_err_r <= 1'b1;
                        if (!stop_idx)   stop0_r     <= sample_bit;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_o   <= 1'b0;
            rx_data_o    <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            rx_valid_o <= done;
            if (done) begin
                rx_data_o    <= brk ? '0 : shreg;
                parity_err_o <= brk ? 1'b0 : par_err_r;
                frame_err_o  <= brk | frame_err_r | ~sample_bit;
                break_o      <= brk;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances checked against a per-instance expectation queue.
module tb_uart_rx_cfg;

    localparam int BIT  = 434;
    localparam int HALF = 217;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        int         t0;
        int         sidx;
    } exp_t;

    logic       clk, rst_n;
    logic       rx0, rx1, rx2;
    logic       v0, v1, v2;
    logic [7:0] d0, d1, d2;
    logic       pe0, pe1, pe2, fe0, fe1, fe2, br0, br1, br2, busy0, busy1, busy2;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rise, fall;
    exp_t q0[$], q1[$], q2[$];

    uart_rx_cfg dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx0), .rx_valid_o(v0), .rx_data_o(d0),
        .parity_err_o(pe0), .frame_err_o(fe0), .break_o(br0), .busy_o(busy0)
    );

    uart_rx_cfg #(.PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx1), .rx_valid_o(v1), .rx_data_o(d1),
        .parity_err_o(pe1), .frame_err_o(fe1), .break_o(br1), .busy_o(busy1)
    );

    uart_rx_cfg #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx2), .rx_valid_o(v2), .rx_data_o(d2),
        .parity_err_o(pe2), .frame_err_o(fe2), .break_o(br2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_rx(input string tag, input exp_t e, input logic [7:0] d,
                            input logic pe, input logic fe, input logic brk);
        int lo, hi;
        lo = e.t0 + e.sidx * BIT;
        hi = e.t0 + e.sidx * BIT + HALF + 220;
        n_tests++;
        assert (d === e.data) else begin
            n_fail++; $error("FAIL %s_data observed=%h expected=%h", tag, d, e.data);
        end
        n_tests++;
        assert (pe === e.pe) else begin
            n_fail++; $error("FAIL %s_parity_err observed=%b expected=%b", tag, pe, e.pe);
        end
        n_tests++;
        assert (fe === e.fe) else begin
            n_fail++; $error("FAIL %s_frame_err observed=%b expected=%b", tag, fe, e.fe);
        end
        n_tests++;
        assert (brk === e.brk) else begin
            n_fail++; $error("FAIL %s_break observed=%b expected=%b", tag, brk, e.brk);
        end
        n_tests++;
        assert (cyc >= lo && cyc <= hi) else begin
            n_fail++; $error("FAIL %s_latency observed cycle=%0d expected %0d..%0d", tag, cyc, lo, hi);
        end
    endtask

    always @(negedge clk) if (rst_n && v0) begin
        n_tests++;
        assert (q0.size() != 0) else begin
            n_fail++; $error("FAIL inst0_unexpected_valid observed data=%h expected no valid", d0);
        end
        if (q0.size() != 0) check_rx("inst0", q0.pop_front(), d0, pe0, fe0, br0);
    end

    always @(negedge clk) if (rst_n && v1) begin
        n_tests++;
        assert (q1.size() != 0) else begin
            n_fail++; $error("FAIL inst1_unexpected_valid observed data=%h expected no valid", d1);
        end
        if (q1.size() != 0) check_rx("inst1", q1.pop_front(), d1, pe1, fe1, br1);
    end

    always @(negedge clk) if (rst_n && v2) begin
        n_tests++;
        assert (q2.size() != 0) else begin
            n_fail++; $error("FAIL inst2_unexpected_valid observed data=%h expected no valid", d2);
        end
        if (q2.size() != 0) check_rx("inst2", q2.pop_front(), d2, pe2, fe2, br2);
    end

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // bits[0] is the start bit; sidx is the bit index whose mid-point carries the final decision.
    task automatic send(input int inst, input logic [15:0] bits, input int n, input int sidx,
                        input logic [7:0] data, input logic pe, input logic fe, input logic brk);
        exp_t e;
        @(posedge clk); #1;
        e.data = data; e.pe = pe; e.fe = fe; e.brk = brk; e.t0 = cyc; e.sidx = sidx;
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        for (int i = 0; i < n; i++) begin
            set_line(inst, bits[i]);
            repeat (BIT) @(posedge clk);
            #1;
        end
        set_line(inst, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        idle(5);
        n_tests++;
        assert ({v0, d0, pe0, fe0, br0, busy0} === 13'h0) else begin
            n_fail++; $error("FAIL reset_inst0 observed=%h expected=0", {v0, d0, pe0, fe0, br0, busy0});
        end
        n_tests++;
        assert ({v1, d1, pe1, fe1, br1, busy1, v2, d2, pe2, fe2, br2, busy2} === 26'h0) else begin
            n_fail++; $error("FAIL reset_inst12 observed=%h expected=0",
                             {v1, d1, pe1, fe1, br1, busy1, v2, d2, pe2, fe2, br2, busy2});
        end
        rst_n = 1'b1;
        idle(20);

        // 8N1 back-to-back
        send(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, 9, 8'hA5, 1'b0, 1'b0, 1'b0);
        send(0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10, 9, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(500);

        // 8E1: wrong then correct parity bit for 0x37 (five ones, even parity bit = 1)
        send(1, {5'h1F, 1'b1, 1'b0, 8'h37, 1'b0}, 11, 10, 8'h37, 1'b1, 1'b0, 1'b0);
        idle(500);
        send(1, {5'h1F, 1'b1, 1'b1, 8'h37, 1'b0}, 11, 10, 8'h37, 1'b0, 1'b0, 1'b0);
        idle(500);

        // 8N2: second stop low, then both high
        send(2, {5'h1F, 1'b0, 1'b1, 8'h81, 1'b0}, 11, 10, 8'h81, 1'b0, 1'b1, 1'b0);
        idle(500);
        send(2, {5'h1F, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 10, 8'h81, 1'b0, 1'b0, 1'b0);
        idle(500);

        // 100-clock glitch: false start, no valid
        rise = -1; fall = -1;
        @(posedge clk); #1;
        rx0 = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (i == 100) rx0 = 1'b1;
            if (rise < 0 && busy0) rise = i;
            if (rise >= 0 && fall < 0 && !busy0) fall = i;
        end
        n_tests++;
        assert (rise >= 0 && rise <= 10) else begin
            n_fail++; $error("FAIL glitch_busy_rise observed=%0d expected 0..10", rise);
        end
        n_tests++;
        assert (fall >= 0 && fall - rise <= 220) else begin
            n_fail++; $error("FAIL glitch_busy_fall observed fall=%0d rise=%0d expected busy span <=220", fall, rise);
        end
        send(0, {6'h3F, 1'b1, 8'h55, 1'b0}, 10, 9, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(500);

        // Break: 12 bit times low -> one valid
        send(0, 16'h0000, 12, 9, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(300);
        n_tests++;
        assert (busy0 === 1'b0) else begin
            n_fail++; $error("FAIL break_idle_busy observed=%b expected=0", busy0);
        end
        send(0, {6'h3F, 1'b1, 8'h99, 1'b0}, 10, 9, 8'h99, 1'b0, 1'b0, 1'b0);
        idle(500);

        // Reset during data bit 4 of 0xF0
        @(posedge clk); #1;
        rx0 = 1'b0;
        idle(5 * BIT);
        rx0 = 1'b1;
        idle(HALF);
        rst_n = 1'b0;
        idle(5);
        n_tests++;
        assert ({v0, d0, pe0, fe0, br0, busy0} === 13'h0) else begin
            n_fail++; $error("FAIL midframe_reset observed=%h expected=0", {v0, d0, pe0, fe0, br0, busy0});
        end
        rst_n = 1'b1;
        idle(500);
        send(0, {6'h3F, 1'b1, 8'h0F, 1'b0}, 10, 9, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle(600);

        n_tests++;
        assert (q0.size() == 0) else begin
            n_fail++; $error("FAIL inst0_missing_valid observed pending=%0d expected=0", q0.size());
        end
        n_tests++;
        assert (q1.size() == 0) else begin
            n_fail++; $error("FAIL inst1_missing_valid observed pending=%0d expected=0", q1.size());
        end
        n_tests++;
        assert (q2.size() == 0) else begin
            n_fail++; $error("FAIL inst2_missing_valid observed pending=%0d expected=0", q2.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
